// File: rtl/gpio_core.sv
// gpio_core: hardware side of the 32-bit GPIO peripheral
//   clk_i, rst_i   single clock, asynchronous active-high reset
//   reg2hw_i       register-file outputs (q/qe fields)
//   hw2reg_o       register-file updates (d/de fields)
//   cio_gpio_i     pad inputs, asynchronous to clk_i
//   cio_gpio_o     pad output data
//   cio_gpio_en_o  pad output enables (1 = drive)
//   intr_gpio_o    per-pin interrupt, level, registered
package gpio_pkg;
    typedef struct packed { logic [31:0] q; } gpio_q32_t;
    typedef struct packed { logic [31:0] q; logic qe; } gpio_q32e_t;
    typedef struct packed { logic [15:0] q; logic qe; } gpio_q16e_t;
    typedef struct packed { gpio_q16e_t data; gpio_q16e_t mask; } gpio_masked_q_t;

    typedef struct packed { logic [31:0] d; logic de; } gpio_d32_t;
    typedef struct packed { logic [15:0] d; logic de; } gpio_d16_t;
    typedef struct packed { gpio_d16_t data; gpio_d16_t mask; } gpio_masked_d_t;

    typedef struct packed {
        gpio_q32_t      intr_state;
        gpio_q32_t      intr_enable;
        gpio_q32e_t     intr_test;
        gpio_q32_t      intr_ctrl_en_rising;
        gpio_q32_t      intr_ctrl_en_falling;
        gpio_q32_t      intr_ctrl_en_lvlhigh;
        gpio_q32_t      intr_ctrl_en_lvllow;
        gpio_q32_t      ctrl_en_input_filter;
        gpio_q32e_t     direct_out;
        gpio_masked_q_t masked_out_lower;
        gpio_masked_q_t masked_out_upper;
        gpio_q32e_t     direct_oe;
        gpio_masked_q_t masked_oe_lower;
        gpio_masked_q_t masked_oe_upper;
    } gpio_reg2hw_t;

    typedef struct packed {
        gpio_d32_t      intr_state;
        gpio_d32_t      data_in;
        gpio_d32_t      direct_out;
        gpio_masked_d_t masked_out_lower;
        gpio_masked_d_t masked_out_upper;
        gpio_d32_t      direct_oe;
        gpio_masked_d_t masked_oe_lower;
        gpio_masked_d_t masked_oe_upper;
    } gpio_hw2reg_t;
endpackage

module gpio_core
    import gpio_pkg::*;
#(
    parameter int FilterCycles = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  gpio_reg2hw_t reg2hw_i,
    output gpio_hw2reg_t hw2reg_o,
    input  logic [31:0]  cio_gpio_i,
    output logic [31:0]  cio_gpio_o,
    output logic [31:0]  cio_gpio_en_o,
    output logic [31:0]  intr_gpio_o
);
    localparam int CW = $clog2(FilterCycles);
    localparam logic [CW-1:0] CMAX = CW'(FilterCycles - 1);

    logic [31:0]   sync1_q, sync1_d, s_q, s_d, s_prev_q, s_prev_d;
    logic [31:0]   filt_q, filt_d, filt_dly_q, filt_dly_d;
    logic [31:0]   out_q, out_d, oe_q, oe_d, intr_q, intr_d;
    logic [31:0]   ev, new_ev;
    logic [CW-1:0] cnt_q [32];
    logic [CW-1:0] cnt_d [32];

    // Masked halves apply independently; a direct write in the same cycle overrides both.
    function automatic logic [31:0] wr_next(logic [31:0] cur, gpio_q32e_t dir,
                                            gpio_masked_q_t lo, gpio_masked_q_t hi);
        logic [31:0] v;
        v = cur;
        if (lo.data.qe && lo.mask.qe) v[15:0] = (lo.data.q & lo.mask.q) | (cur[15:0] & ~lo.mask.q);
        if (hi.data.qe && hi.mask.qe) v[31:16] = (hi.data.q & hi.mask.q) | (cur[31:16] & ~hi.mask.q);
        return dir.qe ? dir.q : v;
    endfunction

    always_comb begin
        sync1_d  = cio_gpio_i;
        s_d      = sync1_q;
        s_prev_d = s_q;
        for (int i = 0; i < 32; i++) begin
            // Held at 0 while unfiltered, so enabling the filter always restarts the count.
            cnt_d[i]  = (!reg2hw_i.ctrl_en_input_filter.q[i] || s_q[i] != s_prev_q[i]) ? '0 :
                        (cnt_q[i] == CMAX ? CMAX : cnt_q[i] + CW'(1));
            filt_d[i] = (!reg2hw_i.ctrl_en_input_filter.q[i] || cnt_d[i] == CMAX) ? s_q[i] : filt_q[i];
        end
        filt_dly_d = filt_q;
        out_d = wr_next(out_q, reg2hw_i.direct_out, reg2hw_i.masked_out_lower, reg2hw_i.masked_out_upper);
        oe_d  = wr_next(oe_q, reg2hw_i.direct_oe, reg2hw_i.masked_oe_lower, reg2hw_i.masked_oe_upper);
        ev = (filt_q & ~filt_dly_q & reg2hw_i.intr_ctrl_en_rising.q)
           | (~filt_q & filt_dly_q & reg2hw_i.intr_ctrl_en_falling.q)
           | (filt_q & reg2hw_i.intr_ctrl_en_lvlhigh.q)
           | (~filt_q & reg2hw_i.intr_ctrl_en_lvllow.q);
        new_ev = ev | (reg2hw_i.intr_test.qe ? reg2hw_i.intr_test.q : '0);
        intr_d = reg2hw_i.intr_state.q & reg2hw_i.intr_enable.q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q    <= '0;
            s_q        <= '0;
            s_prev_q   <= '0;
            filt_q     <= '0;
            filt_dly_q <= '0;
            out_q      <= '0;
            oe_q       <= '0;
            intr_q     <= '0;
            cnt_q      <= '{default: '0};
        end else begin
            sync1_q    <= sync1_d;
            s_q        <= s_d;
            s_prev_q   <= s_prev_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_dly_d;
            out_q      <= out_d;
            oe_q       <= oe_d;
            intr_q     <= intr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Setting de together with the OR-ed value lets a same-cycle event beat a W1C write.
    always_comb begin
        hw2reg_o.intr_state.d            = reg2hw_i.intr_state.q | new_ev;
        hw2reg_o.intr_state.de           = |new_ev;
        hw2reg_o.data_in.d               = filt_q;
        hw2reg_o.data_in.de              = 1'b1;
        hw2reg_o.direct_out.d            = out_q;
        hw2reg_o.direct_out.de           = 1'b1;
        hw2reg_o.masked_out_lower.data.d = out_q[15:0];
        hw2reg_o.masked_out_lower.data.de = 1'b1;
        hw2reg_o.masked_out_lower.mask.d = '0;
        hw2reg_o.masked_out_lower.mask.de = 1'b1;
        hw2reg_o.masked_out_upper.data.d = out_q[31:16];
        hw2reg_o.masked_out_upper.data.de = 1'b1;
        hw2reg_o.masked_out_upper.mask.d = '0;
        hw2reg_o.masked_out_upper.mask.de = 1'b1;
        hw2reg_o.direct_oe.d             = oe_q;
        hw2reg_o.direct_oe.de            = 1'b1;
        hw2reg_o.masked_oe_lower.data.d  = oe_q[15:0];
        hw2reg_o.masked_oe_lower.data.de = 1'b1;
        hw2reg_o.masked_oe_lower.mask.d  = '0;
        hw2reg_o.masked_oe_lower.mask.de = 1'b1;
        hw2reg_o.masked_oe_upper.data.d  = oe_q[31:16];
        hw2reg_o.masked_oe_upper.data.de = 1'b1;
        hw2reg_o.masked_oe_upper.mask.d  = '0;
        hw2reg_o.masked_oe_upper.mask.de = 1'b1;
    end

    assign cio_gpio_o    = out_q;
    assign cio_gpio_en_o = oe_q;
    assign intr_gpio_o   = intr_q;
endmodule

// File: tb/tb_gpio_core.sv
// tb_gpio_core: directed self-checking bench for gpio_core
module tb_gpio_core;
    import gpio_pkg::*;

    logic         clk, rst;
    logic [31:0]  cio_i, cio_o, cio_en, intr;
    gpio_reg2hw_t r2h;
    gpio_hw2reg_t h2r;
    int           total = 0, failed = 0;
    logic         seen;

    gpio_core #(.FilterCycles(16)) dut (
        .clk_i(clk), .rst_i(rst), .reg2hw_i(r2h), .hw2reg_o(h2r),
        .cio_gpio_i(cio_i), .cio_gpio_o(cio_o), .cio_gpio_en_o(cio_en), .intr_gpio_o(intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        cio_i = '0;
        r2h = '0;
        step(2);
        rst = 1'b0;
        step(1);
        // 1: reset state
        check("rst_out", cio_o, 32'h0);
        check("rst_en", cio_en, 32'h0);
        check("rst_intr", intr, 32'h0);
        check("rst_din_d", h2r.data_in.d, 32'h0);
        check("rst_din_de", 32'(h2r.data_in.de), 32'h1);
        check("rst_is_de", 32'(h2r.intr_state.de), 32'h0);

        // 2: direct then masked lower write
        r2h.direct_out = '{q: 32'hA5A5_0000, qe: 1'b1};
        step(1);
        r2h.direct_out.qe = 1'b0;
        check("direct_out", cio_o, 32'hA5A5_0000);
        r2h.masked_out_lower = '{data: '{q: 16'h00FF, qe: 1'b1}, mask: '{q: 16'h0F0F, qe: 1'b1}};
        step(1);
        r2h.masked_out_lower = '0;
        check("masked_lo", cio_o, 32'hA5A5_000F);
        check("rb_lo_data", 32'(h2r.masked_out_lower.data.d), 32'h0000_000F);
        check("rb_lo_mask", 32'(h2r.masked_out_lower.mask.d), 32'h0);
        check("rb_hi_data", 32'(h2r.masked_out_upper.data.d), 32'h0000_A5A5);
        check("rb_direct", h2r.direct_out.d, 32'hA5A5_000F);
        // data qe without mask qe must not write
        r2h.masked_out_upper = '{data: '{q: 16'hFFFF, qe: 1'b1}, mask: '{q: 16'hFFFF, qe: 1'b0}};
        step(1);
        r2h.masked_out_upper = '0;
        check("masked_no_mask_qe", cio_o, 32'hA5A5_000F);

        // 3: rising edge interrupt on pin 3, unfiltered
        r2h.intr_ctrl_en_rising.q = 32'h8;
        r2h.intr_enable.q = 32'h8;
        cio_i[3] = 1'b1;
        step(2);
        check("rise_early_de", 32'(h2r.intr_state.de), 32'h0);
        step(1);
        check("rise_de", 32'(h2r.intr_state.de), 32'h1);
        check("rise_d", h2r.intr_state.d, 32'h8);
        step(1);
        check("rise_de_drop", 32'(h2r.intr_state.de), 32'h0);
        check("intr_pre", intr, 32'h0);
        r2h.intr_state.q = 32'h8;
        step(1);
        check("intr_out", intr, 32'h8);
        r2h.intr_enable.q = 32'h0;
        step(1);
        check("intr_masked", intr, 32'h0);
        r2h.intr_state.q = 32'h0;
        r2h.intr_ctrl_en_rising.q = 32'h0;
        r2h.intr_ctrl_en_lvlhigh.q = 32'h8;
        #1;
        check("lvlhigh_de", 32'(h2r.intr_state.de), 32'h1);
        check("lvlhigh_d", h2r.intr_state.d, 32'h8);
        r2h.intr_ctrl_en_lvlhigh.q = 32'h0;
        r2h.intr_ctrl_en_falling.q = 32'h8;
        cio_i[3] = 1'b0;
        step(2);
        check("fall_early_de", 32'(h2r.intr_state.de), 32'h0);
        step(1);
        check("fall_d", h2r.intr_state.d, 32'h8);
        r2h.intr_ctrl_en_falling.q = 32'h0;
        step(2);

        // 5: interrupt test injection
        r2h.intr_test = '{q: 32'h8000_0001, qe: 1'b0};
        #1;
        check("itest_no_qe", 32'(h2r.intr_state.de), 32'h0);
        r2h.intr_test.qe = 1'b1;
        #1;
        check("itest_d", h2r.intr_state.d, 32'h8000_0001);
        check("itest_de", 32'(h2r.intr_state.de), 32'h1);
        step(1);
        r2h.intr_test = '0;

        // 4: input filter on bit 5
        r2h.ctrl_en_input_filter.q = 32'h20;
        step(20);
        cio_i[5] = 1'b1;
        step(10);
        cio_i[5] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            seen |= h2r.data_in.d[5];
        end
        check("glitch10", 32'(seen), 32'h0);
        cio_i[5] = 1'b1;
        step(15);
        cio_i[5] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            seen |= h2r.data_in.d[5];
        end
        check("glitch15", 32'(seen), 32'h0);
        cio_i[5] = 1'b1;
        step(17);
        check("filt_rise_17", 32'(h2r.data_in.d[5]), 32'h0);
        step(1);
        check("filt_rise_18", 32'(h2r.data_in.d[5]), 32'h1);
        step(2);
        cio_i[5] = 1'b0;
        step(17);
        check("filt_fall_17", 32'(h2r.data_in.d[5]), 32'h1);
        step(1);
        check("filt_fall_18", 32'(h2r.data_in.d[5]), 32'h0);
        r2h.ctrl_en_input_filter.q = 32'h0;

        // 6: direct_oe beats same-cycle masked_oe_upper, then masked upper alone, then reset
        r2h.direct_oe = '{q: 32'hFFFF_FFFF, qe: 1'b1};
        r2h.masked_oe_upper = '{data: '{q: 16'h0000, qe: 1'b1}, mask: '{q: 16'hFFFF, qe: 1'b1}};
        step(1);
        r2h.direct_oe = '0;
        r2h.masked_oe_upper = '0;
        check("oe_direct_wins", cio_en, 32'hFFFF_FFFF);
        r2h.masked_oe_upper = '{data: '{q: 16'h1234, qe: 1'b1}, mask: '{q: 16'hFF00, qe: 1'b1}};
        step(1);
        r2h.masked_oe_upper = '0;
        check("oe_masked_hi", cio_en, 32'h12FF_FFFF);
        check("rb_oe", h2r.direct_oe.d, 32'h12FF_FFFF);
        r2h.intr_ctrl_en_rising.q = 32'hFFFF_FFFF;
        rst = 1'b1;
        #1;
        check("rst_en_async", cio_en, 32'h0);
        check("rst_out_async", cio_o, 32'h0);
        step(1);
        rst = 1'b0;
        step(3);
        check("post_rst_de", 32'(h2r.intr_state.de), 32'h0);
        check("post_rst_en", cio_en, 32'h0);

        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end
endmodule
